// File: rtl/display_timings_pkg.sv
// Video mode table (640x480, 800x600, 1280x720, 1920x1080) and helpers that
// derive signed counter bounds and sync windows from it.
package display_timings_pkg;

   typedef struct packed {
      logic [15:0] h_res;
      logic [15:0] h_fp;
      logic [15:0] h_sync;
      logic [15:0] h_bp;
      logic [15:0] v_res;
      logic [15:0] v_fp;
      logic [15:0] v_sync;
      logic [15:0] v_bp;
      logic        h_pol;
      logic        v_pol;
   } mode_t;

   localparam mode_t MODE_TABLE [4] = '{
      '{16'd640,  16'd16,  16'd96,  16'd48,  16'd480,  16'd10, 16'd2, 16'd33, 1'b0, 1'b0},
      '{16'd800,  16'd40,  16'd128, 16'd88,  16'd600,  16'd1,  16'd4, 16'd23, 1'b1, 1'b1},
      '{16'd1280, 16'd110, 16'd40,  16'd220, 16'd720,  16'd5,  16'd5, 16'd20, 1'b1, 1'b1},
      '{16'd1920, 16'd88,  16'd44,  16'd148, 16'd1080, 16'd4,  16'd5, 16'd36, 1'b1, 1'b1}
   };

   function automatic int get_h_sta(input logic [1:0] m);
      return -(int'(MODE_TABLE[m].h_fp) + int'(MODE_TABLE[m].h_sync) + int'(MODE_TABLE[m].h_bp));
   endfunction

   function automatic int get_h_end(input logic [1:0] m);
      return int'(MODE_TABLE[m].h_res) - 1;
   endfunction

   function automatic int get_v_sta(input logic [1:0] m);
      return -(int'(MODE_TABLE[m].v_fp) + int'(MODE_TABLE[m].v_sync) + int'(MODE_TABLE[m].v_bp));
   endfunction

   function automatic int get_v_end(input logic [1:0] m);
      return int'(MODE_TABLE[m].v_res) - 1;
   endfunction

   // Sync window is [beg, end) in counter coordinates.
   function automatic int get_hs_beg(input logic [1:0] m);
      return get_h_sta(m) + int'(MODE_TABLE[m].h_fp);
   endfunction

   function automatic int get_hs_end(input logic [1:0] m);
      return get_hs_beg(m) + int'(MODE_TABLE[m].h_sync);
   endfunction

   function automatic int get_vs_beg(input logic [1:0] m);
      return get_v_sta(m) + int'(MODE_TABLE[m].v_fp);
   endfunction

   function automatic int get_vs_end(input logic [1:0] m);
      return get_vs_beg(m) + int'(MODE_TABLE[m].v_sync);
   endfunction

   function automatic bit mode_fits(input logic [1:0] m, input int w);
      int h_tot;
      int v_tot;
      h_tot = int'(MODE_TABLE[m].h_res) - get_h_sta(m);
      v_tot = int'(MODE_TABLE[m].v_res) - get_v_sta(m);
      return (h_tot < 2 ** (w - 1)) && (v_tot < 2 ** (w - 1));
   endfunction

endpackage

// File: rtl/display_timings_mm_decode.sv
// dt_mode_decode: combinational lookup from a mode index to its signed counter
// bounds, sync windows and sync polarities.
module dt_mode_decode
   import display_timings_pkg::*;
#(
   parameter int CORD_W = 16
) (
   input  logic              [1:0]        i_mode,
   output logic signed       [CORD_W-1:0] o_h_sta,
   output logic signed       [CORD_W-1:0] o_h_end,
   output logic signed       [CORD_W-1:0] o_hs_beg,
   output logic signed       [CORD_W-1:0] o_hs_end,
   output logic signed       [CORD_W-1:0] o_v_sta,
   output logic signed       [CORD_W-1:0] o_v_end,
   output logic signed       [CORD_W-1:0] o_vs_beg,
   output logic signed       [CORD_W-1:0] o_vs_end,
   output logic                            o_h_pol,
   output logic                            o_v_pol
);

   assign o_h_sta  = CORD_W'(get_h_sta(i_mode));
   assign o_h_end  = CORD_W'(get_h_end(i_mode));
   assign o_hs_beg = CORD_W'(get_hs_beg(i_mode));
   assign o_hs_end = CORD_W'(get_hs_end(i_mode));
   assign o_v_sta  = CORD_W'(get_v_sta(i_mode));
   assign o_v_end  = CORD_W'(get_v_end(i_mode));
   assign o_vs_beg = CORD_W'(get_vs_beg(i_mode));
   assign o_vs_end = CORD_W'(get_vs_end(i_mode));
   assign o_h_pol  = MODE_TABLE[i_mode].h_pol;
   assign o_v_pol  = MODE_TABLE[i_mode].v_pol;

endmodule

// File: rtl/display_timings_mm.sv
// Multi-mode display timing generator: signed sx/sy counters, sync/de/strobes,
// mode switch applied at frame end. Line IRQ built only with DISPLAY_TIMINGS_LINE_IRQ_EN.
module display_timings_mm
   import display_timings_pkg::*;
#(
   parameter int NUM_MODES    = 4,
   parameter int DEFAULT_MODE = 2,
   parameter int CORD_W       = 16
) (
   input  logic                     i_pix_clk,
   input  logic                     i_rst_n,
   input  logic                     i_mode_req,
   input  logic [1:0]               i_mode_sel,
   input  logic signed [CORD_W-1:0] i_irq_line,
   output logic                     o_hs,
   output logic                     o_vs,
   output logic                     o_de,
   output logic                     o_frame,
   output logic                     o_line,
   output logic                     o_line_irq,
   output logic signed [CORD_W-1:0] o_sx,
   output logic signed [CORD_W-1:0] o_sy,
   output logic [1:0]               o_mode,
   output logic                     o_mode_ack,
   output logic                     o_mode_err
);

   typedef struct packed {
      logic signed [CORD_W-1:0] h_sta;
      logic signed [CORD_W-1:0] h_end;
      logic signed [CORD_W-1:0] hs_beg;
      logic signed [CORD_W-1:0] hs_end;
      logic signed [CORD_W-1:0] v_sta;
      logic signed [CORD_W-1:0] v_end;
      logic signed [CORD_W-1:0] vs_beg;
      logic signed [CORD_W-1:0] vs_end;
      logic                     h_pol;
      logic                     v_pol;
   } bnd_t;

   localparam logic [1:0] DEF = 2'(DEFAULT_MODE);
   localparam logic signed [CORD_W-1:0] ONE = CORD_W'(1);
   localparam bnd_t CFG_RST = '{
      h_sta:  CORD_W'(get_h_sta(DEF)),
      h_end:  CORD_W'(get_h_end(DEF)),
      hs_beg: CORD_W'(get_hs_beg(DEF)),
      hs_end: CORD_W'(get_hs_end(DEF)),
      v_sta:  CORD_W'(get_v_sta(DEF)),
      v_end:  CORD_W'(get_v_end(DEF)),
      vs_beg: CORD_W'(get_vs_beg(DEF)),
      vs_end: CORD_W'(get_vs_end(DEF)),
      h_pol:  MODE_TABLE[DEF].h_pol,
      v_pol:  MODE_TABLE[DEF].v_pol
   };

   if (NUM_MODES < 1 || NUM_MODES > 4 || DEFAULT_MODE < 0 || DEFAULT_MODE >= NUM_MODES) begin : g_par_err
      $error("display_timings_mm: NUM_MODES/DEFAULT_MODE out of range");
   end
   for (genvar m = 0; m < NUM_MODES; m++) begin : g_fit
      if (!mode_fits(2'(m), CORD_W)) begin : g_fit_err
         $error("display_timings_mm: mode %0d does not fit in CORD_W-1 bits", m);
      end
   end

   bnd_t                     cfg_q, cfg_d, dec;
   logic signed [CORD_W-1:0] sx_q, sx_d, sy_q, sy_d;
   logic [1:0]               mode_q, mode_d, sel_q, sel_d, sel_eff;
   logic                     pending_q, pending_d;
   logic                     hs_q, hs_d, vs_q, vs_d, de_q, de_d;
   logic                     frame_q, frame_d, line_q, line_d, irq_q, irq_d;
   logic                     ack_q, ack_d, err_q, err_d;
   logic                     req_ok, req_bad, pend_eff, h_wrap, v_wrap, apply;

   dt_mode_decode #(.CORD_W(CORD_W)) u_decode (
      .i_mode   (mode_d),
      .o_h_sta  (dec.h_sta),
      .o_h_end  (dec.h_end),
      .o_hs_beg (dec.hs_beg),
      .o_hs_end (dec.hs_end),
      .o_v_sta  (dec.v_sta),
      .o_v_end  (dec.v_end),
      .o_vs_beg (dec.vs_beg),
      .o_vs_end (dec.vs_end),
      .o_h_pol  (dec.h_pol),
      .o_v_pol  (dec.v_pol)
   );

   always_comb begin
      req_ok   = i_mode_req && (int'(i_mode_sel) < NUM_MODES);
      req_bad  = i_mode_req && !req_ok;
      // A request landing on the apply cycle replaces whatever was pending.
      pend_eff = pending_q || req_ok;
      sel_eff  = req_ok ? i_mode_sel : sel_q;
      h_wrap   = (sx_q == cfg_q.h_end);
      v_wrap   = (sy_q == cfg_q.v_end);
      apply    = pend_eff && h_wrap && v_wrap;

      mode_d    = apply ? sel_eff : mode_q;
      cfg_d     = apply ? dec : cfg_q;
      pending_d = pend_eff && !apply;
      sel_d     = sel_eff;

      sx_d = h_wrap ? cfg_d.h_sta : sx_q + ONE;
      sy_d = sy_q;
      if (h_wrap) begin
         sy_d = v_wrap ? cfg_d.v_sta : sy_q + ONE;
      end

      // Outputs are decoded from the next position so they register alongside it.
      hs_d    = (($signed(sx_d) >= $signed(cfg_d.hs_beg)) && ($signed(sx_d) < $signed(cfg_d.hs_end)))
                ? cfg_d.h_pol : ~cfg_d.h_pol;
      vs_d    = (($signed(sy_d) >= $signed(cfg_d.vs_beg)) && ($signed(sy_d) < $signed(cfg_d.vs_end)))
                ? cfg_d.v_pol : ~cfg_d.v_pol;
      de_d    = !sx_d[CORD_W-1] && !sy_d[CORD_W-1];
      line_d  = h_wrap;
      frame_d = h_wrap && v_wrap;
      ack_d   = apply;
      err_d   = req_bad;
`ifdef DISPLAY_TIMINGS_LINE_IRQ_EN
      irq_d   = h_wrap && (sy_d == i_irq_line);
`else
      irq_d   = 1'b0;
`endif
   end

`ifndef DISPLAY_TIMINGS_LINE_IRQ_EN
   logic unused_irq_line;
   assign unused_irq_line = ^i_irq_line;
`endif

   always_ff @(posedge i_pix_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         cfg_q     <= CFG_RST;
         sx_q      <= CFG_RST.h_sta;
         sy_q      <= CFG_RST.v_sta;
         mode_q    <= DEF;
         sel_q     <= DEF;
         pending_q <= 1'b0;
         hs_q      <= ~CFG_RST.h_pol;
         vs_q      <= ~CFG_RST.v_pol;
         de_q      <= 1'b0;
         frame_q   <= 1'b0;
         line_q    <= 1'b0;
         irq_q     <= 1'b0;
         ack_q     <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         cfg_q     <= cfg_d;
         sx_q      <= sx_d;
         sy_q      <= sy_d;
         mode_q    <= mode_d;
         sel_q     <= sel_d;
         pending_q <= pending_d;
         hs_q      <= hs_d;
         vs_q      <= vs_d;
         de_q      <= de_d;
         frame_q   <= frame_d;
         line_q    <= line_d;
         irq_q     <= irq_d;
         ack_q     <= ack_d;
         err_q     <= err_d;
      end
   end

   assign o_sx       = sx_q;
   assign o_sy       = sy_q;
   assign o_hs       = hs_q;
   assign o_vs       = vs_q;
   assign o_de       = de_q;
   assign o_frame    = frame_q;
   assign o_line     = line_q;
   assign o_line_irq = irq_q;
   assign o_mode     = mode_q;
   assign o_mode_ack = ack_q;
   assign o_mode_err = err_q;

endmodule

// File: tb/tb_display_timings_mm.sv
// Directed bench for display_timings_mm; frame ends are reached by jumping the
// vertical counter at a line wrap, keeping the run short.
module tb_display_timings_mm;

`ifdef DISPLAY_TIMINGS_LINE_IRQ_EN
   localparam int EXP_IRQ = 1;
`else
   localparam int EXP_IRQ = 0;
`endif

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic               req = 1'b0, req3 = 1'b0;
   logic [1:0]         sel = 2'd0, sel3 = 2'd0;
   logic signed [15:0] irq_line = 16'sh7fff;
   logic signed [15:0] jump_y = '0;

   logic               hs, vs, de, frame, line, irq, ack, err;
   logic signed [15:0] sx, sy;
   logic [1:0]         mode;
   logic               hs3, vs3, de3, frame3, line3, irq3, ack3, err3;
   logic signed [15:0] sx3, sy3;
   logic [1:0]         mode3;

   int n_chk = 0, n_err = 0;
   int ack_cnt = 0, irq_cnt = 0;

   always #5 clk = ~clk;

   display_timings_mm dut (
      .i_pix_clk(clk), .i_rst_n(rst_n), .i_mode_req(req), .i_mode_sel(sel),
      .i_irq_line(irq_line), .o_hs(hs), .o_vs(vs), .o_de(de), .o_frame(frame),
      .o_line(line), .o_line_irq(irq), .o_sx(sx), .o_sy(sy), .o_mode(mode),
      .o_mode_ack(ack), .o_mode_err(err)
   );

   display_timings_mm #(.NUM_MODES(3)) dut3 (
      .i_pix_clk(clk), .i_rst_n(rst_n), .i_mode_req(req3), .i_mode_sel(sel3),
      .i_irq_line(irq_line), .o_hs(hs3), .o_vs(vs3), .o_de(de3), .o_frame(frame3),
      .o_line(line3), .o_line_irq(irq3), .o_sx(sx3), .o_sy(sy3), .o_mode(mode3),
      .o_mode_ack(ack3), .o_mode_err(err3)
   );

   always @(negedge clk) begin
      if (ack) ack_cnt++;
      if (irq) irq_cnt++;
   end

   task automatic chk(input string tag, input longint act, input longint exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
      end
   endtask

   task automatic chk_reset(input string p);
      chk({p, "_sx"}, sx, -370);
      chk({p, "_sy"}, sy, -30);
      chk({p, "_hs"}, hs, 0);
      chk({p, "_vs"}, vs, 0);
      chk({p, "_mode"}, mode, 2);
      chk({p, "_de"}, de, 0);
      chk({p, "_frame"}, frame, 0);
      chk({p, "_line"}, line, 0);
      chk({p, "_ack"}, ack, 0);
      chk({p, "_err"}, err, 0);
      chk({p, "_irq"}, irq, 0);
   endtask

   task automatic wait_sx(input int v);
      int n = 0;
      while ($signed(sx) != v && n < 2400) begin
         @(negedge clk);
         n++;
      end
      chk("wait_sx_reached", ($signed(sx) == v), 1);
   endtask

   task automatic pulse_req(input logic [1:0] s);
      req = 1'b1;
      sel = s;
      @(negedge clk);
      req = 1'b0;
   endtask

   // Skip to line y: at the end of the current line the next-row value is overridden.
   task automatic jump(input int hend, input int y);
      wait_sx(hend);
      jump_y = 16'(y);
      force dut.sy_d = jump_y;
      @(posedge clk);
      #1 release dut.sy_d;
      @(negedge clk);
      chk("jump_sy", sy, y);
      chk("jump_line", line, 1);
   endtask

   task automatic measure(input int n, output int hs_hi, output int de_hi, output int vs_hi,
                          output int lines, output int sx_max, output int sx_min);
      hs_hi = 0; de_hi = 0; vs_hi = 0; lines = 0; sx_max = -32768; sx_min = 32767;
      for (int i = 0; i < n; i++) begin
         hs_hi += int'(hs);
         de_hi += int'(de);
         vs_hi += int'(vs);
         lines += int'(line);
         if ($signed(sx) > sx_max) sx_max = $signed(sx);
         if ($signed(sx) < sx_min) sx_min = $signed(sx);
         @(negedge clk);
      end
   endtask

   initial begin
      int h, d, v, l, mx, mn, base, n;

      // Reset state of both instances.
      repeat (3) @(negedge clk);
      chk_reset("rst");
      chk("rst3_sx", sx3, -370);
      chk("rst3_mode", mode3, 2);
      rst_n = 1'b1;
      @(negedge clk);
      chk("first_count_sx", sx, -369);
      chk("first_no_line", line, 0);
      chk("first_no_frame", frame, 0);

      // Invalid index on the 3-mode instance.
      req3 = 1'b1;
      sel3 = 2'd3;
      @(negedge clk);
      req3 = 1'b0;
      chk("err3_pulse", err3, 1);
      chk("err3_no_ack", ack3, 0);
      @(negedge clk);
      chk("err3_clear", err3, 0);
      chk("err3_mode", mode3, 2);
      chk("err3_ack", ack3, 0);

      // First line wrap in mode 2.
      n = 0;
      while (line !== 1'b1 && n < 1700) begin
         @(negedge clk);
         n++;
      end
      chk("line1_sx", sx, -370);
      chk("line1_sy", sy, -29);
      chk("line1_frame", frame, 0);
      measure(1650, h, d, v, l, mx, mn);
      chk("m2_hs_hi", h, 40);
      chk("m2_de_blank", d, 0);
      chk("m2_lines", l, 1);
      chk("m2_sx_max", mx, 1279);
      chk("m2_sx_min", mn, -370);
      chk("m2_period_line", line, 1);
      chk("m2_next_sy", sy, -28);

      // Last vsync line, then first active line.
      jump(1279, -21);
      measure(1650, h, d, v, l, mx, mn);
      chk("m2_vs_hi", v, 1650);
      chk("m2_vs_off", vs, 0);
      jump(1279, 0);
      measure(1650, h, d, v, l, mx, mn);
      chk("m2_de_line", d, 1280);
      chk("m2_hs_hi_act", h, 40);
      chk("m2_vs_act", v, 0);

      // Mode 0 request mid-frame: nothing until (1279, 719).
      base = ack_cnt;
      pulse_req(2'd0);
      chk("req0_no_err", err, 0);
      chk("req0_mode_hold", mode, 2);
      jump(1279, 719);
      wait_sx(1279);
      chk("pre_apply_sy", sy, 719);
      chk("pre_apply_mode", mode, 2);
      chk("pre_apply_acks", ack_cnt - base, 0);
      @(negedge clk);
      chk("apply0_sx", sx, -160);
      chk("apply0_sy", sy, -45);
      chk("apply0_mode", mode, 0);
      chk("apply0_ack", ack, 1);
      chk("apply0_frame", frame, 1);
      chk("apply0_hs", hs, 1);
      chk("apply0_vs", vs, 1);
      measure(800, h, d, v, l, mx, mn);
      chk("m0_hs_low", 800 - h, 96);
      chk("m0_lines", l, 1);
      chk("m0_sx_max", mx, 639);
      chk("m0_sx_min", mn, -160);
      chk("m0_period_sx", sx, -160);
      chk("m0_next_sy", sy, -44);
      chk("m0_ack_once", ack_cnt - base, 1);

      // Two requests in one frame: latest wins, one ack.
      base = ack_cnt;
      pulse_req(2'd1);
      repeat (5) @(negedge clk);
      pulse_req(2'd3);
      chk("req3_no_err", err, 0);
      jump(639, 479);
      wait_sx(639);
      chk("pre3_mode", mode, 0);
      @(negedge clk);
      chk("apply3_sx", sx, -280);
      chk("apply3_sy", sy, -45);
      chk("apply3_mode", mode, 3);
      chk("apply3_frame", frame, 1);
      measure(2200, h, d, v, l, mx, mn);
      chk("m3_hs_hi", h, 44);
      chk("m3_lines", l, 1);
      chk("m3_sx_max", mx, 1919);
      chk("m3_sx_min", mn, -280);
      chk("m3_period_line", line, 1);
      chk("m3_ack_once", ack_cnt - base, 1);

      // Same-mode request on the apply cycle overrides a pending sel=0.
      base = ack_cnt;
      pulse_req(2'd0);
      jump(1919, 1079);
      wait_sx(1919);
      req = 1'b1;
      sel = 2'd3;
      @(negedge clk);
      req = 1'b0;
      chk("late_mode", mode, 3);
      chk("late_ack", ack, 1);
      chk("late_frame", frame, 1);
      chk("late_sx", sx, -280);
      @(negedge clk);
      chk("late_ack_once", ack_cnt - base, 1);

      // Asynchronous reset mid-line with a request pending.
      pulse_req(2'd1);
      wait_sx(500);
      #2 rst_n = 1'b0;
      #1 chk_reset("arst");
      @(negedge clk);
      rst_n = 1'b1;
      base = ack_cnt;
      jump(1279, 719);
      wait_sx(1279);
      @(negedge clk);
      chk("post_rst_mode", mode, 2);
      chk("post_rst_ack", ack, 0);
      chk("post_rst_frame", frame, 1);
      chk("post_rst_sx", sx, -370);
      chk("post_rst_sy", sy, -30);
      chk("post_rst_acks", ack_cnt - base, 0);

      // Line interrupt at line 100 of mode 2.
      irq_line = 16'sd100;
      jump(1279, 99);
      wait_sx(1279);
      @(negedge clk);
      chk("irq_sy", sy, 100);
      chk("irq_sx", sx, -370);
      chk("irq_pulse", irq, EXP_IRQ);
      @(negedge clk);
      chk("irq_clear", irq, 0);
      chk("irq_total", irq_cnt, EXP_IRQ);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/display_timings_mm.md
# display_timings_mm

Multi-mode, parametrised display timing generator; successor to the fixed-mode timing generator between the display clocks and the gfx/HDMI generator path. Holds a table of up to four video modes, generates signed screen coordinates, sync, data-enable and frame/line strobes for the active mode, and switches mode at runtime via a request/ack handshake that takes effect only on a frame boundary. Pixel-clock retuning for the new mode is outside this block; `o_mode` feeds the clock reconfiguration logic.

## Interface
- `NUM_MODES`, 4: modes enabled from the package table (1–4). Mode indices ≥ `NUM_MODES` are invalid.
- `DEFAULT_MODE`, 2: mode selected out of reset (720p). Must be < `NUM_MODES`.
- `CORD_W`, 16: coordinate width. Coordinates are signed.
- `i_pix_clk` in 1: pixel clock; the only clock.
- `i_rst_n` in 1: asynchronous, active-low reset.
- `i_mode_req` in 1: mode change request, sampled every cycle while high.
- `i_mode_sel` in 2: requested mode index, valid with `i_mode_req`.
- `i_irq_line` in `CORD_W`: signed line number for the line interrupt.
- `o_hs` out 1: horizontal sync, polarity per mode.
- `o_vs` out 1: vertical sync, polarity per mode.
- `o_de` out 1: data enable.
- `o_frame` out 1: one-cycle frame-start strobe.
- `o_line` out 1: one-cycle line-start strobe.
- `o_line_irq` out 1: one-cycle line-match strobe.
- `o_sx` out `CORD_W`: signed horizontal position.
- `o_sy` out `CORD_W`: signed vertical position.
- `o_mode` out 2: active mode index.
- `o_mode_ack` out 1: one-cycle pulse when a pending request is applied.
- `o_mode_err` out 1: one-cycle pulse when a request is rejected.

## Operation
- Per mode: H_RES, H_FP, H_SYNC, H_BP, V_*, H_POL, V_POL. Mode table: 0 = 640x480, 1 = 800x600, 2 = 1280x720, 3 = 1920x1080, with the standard CEA/VESA values.
- Derived values:
  - H_STA = −(H_FP + H_SYNC + H_BP); H_END = H_RES − 1.
  - V_STA = −(V_FP + V_SYNC + V_BP); V_END = V_RES − 1.
- Horizontal counting: sx counts H_STA..H_END, then wraps to H_STA.
- Vertical counting: sy increments on each horizontal wrap; after V_END it wraps to V_STA.
- Sync:
  - hs is active while H_STA + H_FP ≤ sx < H_STA + H_FP + H_SYNC.
  - vs is active while V_STA + V_FP ≤ sy < V_STA + V_FP + V_SYNC.
  - The active level equals POL; otherwise the output is at the inverted level.
- `o_de` = (sx ≥ 0) && (sy ≥ 0).
- `o_line` is asserted when sx == H_STA after a wrap.
- `o_frame` is asserted when (sx, sy) == (H_STA, V_STA) after a wrap.
- Mode request handling:
  - A request with a valid sel sets `pending` and latches sel. A later request overwrites the latched sel (latest wins).
  - A request with an invalid sel pulses `o_mode_err` and is otherwise ignored; any pending request is kept.
  - A request with sel == the current mode is still latched and acked.
- Applying a pending request:
  - It is applied on the cycle the counters are at (H_END, V_END).
  - On the next edge the counters load the new mode's (H_STA, V_STA), `o_mode` updates, `o_mode_ack` pulses, `o_frame` pulses and `pending` clears.
  - If a request arrives on the apply cycle itself, that request is applied and the older one is dropped.
- Arithmetic: all comparisons are signed, at `CORD_W` bits. Table values fit in `CORD_W` − 1 bits; this is checked by an elaboration assertion.

## Timing
- All outputs are registered and mutually consistent: the sync, de and strobes match `o_sx`/`o_sy` on the same cycle.
- Reset values:
  - `o_sx` = H_STA and `o_sy` = V_STA of `DEFAULT_MODE`.
  - `o_hs` = ~H_POL and `o_vs` = ~V_POL of `DEFAULT_MODE`.
  - `o_mode` = `DEFAULT_MODE`.
  - `o_de`, `o_frame`, `o_line`, `o_line_irq`, `o_mode_ack`, `o_mode_err` and `pending` are 0.
- After reset release, counting starts on the first edge.
- No `o_frame` or `o_line` pulse occurs for the reset-loaded position. The first `o_frame` is at the first V wrap.
- Reset asserted mid-frame or mid-request clears all state immediately (asynchronous), including `pending`.
- Request-to-ack latency: at most one full frame of the current mode plus 1 cycle.
- `o_mode_err` is asserted 1 cycle after the request is sampled.

## Configuration
- Macro: `DISPLAY_TIMINGS_LINE_IRQ_EN`.
- With the macro defined: `o_line_irq` pulses for one cycle, coincident with `o_line`, when the new line's sy == `i_irq_line`. `i_irq_line` is sampled at each line start.
- Without the macro: `o_line_irq` is tied to 0, `i_irq_line` is unused, and no compare logic is built. The ports remain, so the interface is stable.

## Structure
- Package `display_timings_pkg` holds:
  - the `mode_t` struct typedef;
  - the `MODE_TABLE[4]` constant;
  - functions returning H_STA, H_END, V_STA and V_END per mode.
- Sub-module `dt_mode_decode`: a combinational lookup from mode index to the derived bounds and polarities. It is instantiated once for the active mode, and its outputs are registered on each mode switch.
- Counters, the request latch and output decode live in `display_timings_mm`.

## Test plan
- Reset with `DEFAULT_MODE` = 2, run 2 frames:
  - `o_sx` spans −370..1279 and `o_sy` spans −30..719.
  - Each frame is 1650×750 = 1,237,500 cycles.
  - `o_de` is high for 921,600 cycles per frame.
  - `o_hs` is high for 40 cycles per line.
- Request sel = 0 mid-frame:
  - No change until (1279, 719).
  - On the next cycle `o_sx` = −160, `o_sy` = −45, `o_mode` = 0, `o_mode_ack` = 1 and `o_frame` = 1.
  - The following frame is 800×525 and `o_hs` is low-active for 96 cycles.
- Requests sel = 1 then sel = 3 in the same frame:
  - Exactly one ack, and `o_mode` becomes 3.
  - The following frame is 2200×1125.
- Request with sel = 3 while `NUM_MODES` = 3:
  - `o_mode_err` pulses 1 cycle later.
  - There is no ack and the mode is unchanged.
- With `DISPLAY_TIMINGS_LINE_IRQ_EN` defined and `i_irq_line` = 100 in mode 2:
  - Exactly one `o_line_irq` per frame, at sx = −370, sy = 100.
  - Without the macro, `o_line_irq` is never 1.
- Assert `i_rst_n` low at sx = 500 with a request pending:
  - Outputs return to their reset values asynchronously.
  - After release there is no ack, and the mode equals `DEFAULT_MODE`.
